// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the front end: opcode constants, the NOP
// encoding and the fetch FSM state type.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// valid/ready request channel and holds the instruction until the core retires it.
//
// state   | meaning
// S_REQ   | request for PC on the bus, waiting for imem_req_ready
// S_WAIT  | request accepted, waiting for the response
// S_HOLD  | instruction held for decode until instr_ready
// S_FAULT | misaligned target or bus error; terminal until reset
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            fetch_fault
);

    fetch_state_t    state_q, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] instr_q, instr_nxt;
    logic [XLEN-1:0] retire_pc;

    // Adder wraps modulo 2^XLEN by construction.
    assign retire_pc = branch_taken ? branch_target : (pc_q + XLEN'(4));

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_nxt = S_FAULT;
                    end else begin
                        instr_nxt = imem_rsp_data;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    if (retire_pc[1:0] != 2'b00) begin
                        state_nxt = S_FAULT;
                    end else begin
                        pc_nxt    = retire_pc;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= XLEN'(NOP_INSTR);
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
        end
    end

    // Request valid is masked while reset is held so nothing is offered to memory.
    assign imem_req_valid = rst_n && (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign fetch_fault    = (state_q == S_FAULT);
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign opcode         = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7         = instr_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .pc(pc), .branch_taken(branch_taken), .branch_target(branch_target),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Transaction-level model: where the current fetch is in its life.
    typedef enum {PH_ISSUE, PH_INFLIGHT, PH_HELD, PH_DEAD} phase_t;
    phase_t      m_phase = PH_ISSUE;
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_instr = NOP;

    always @(posedge clk) begin
        logic [32:0] target;
        if (!rst_n) begin
            m_phase = PH_ISSUE;
            m_pc    = RST_PC;
            m_instr = NOP;
        end else begin
            case (m_phase)
                PH_ISSUE:    if (imem_req_ready) m_phase = PH_INFLIGHT;
                PH_INFLIGHT: if (imem_rsp_valid) begin
                    if (imem_rsp_err) m_phase = PH_DEAD;
                    else begin
                        m_instr = imem_rsp_data;
                        m_phase = PH_HELD;
                    end
                end
                PH_HELD: if (instr_ready) begin
                    target = branch_taken ? {1'b0, branch_target} : ({1'b0, m_pc} + 33'd4);
                    target = target % 33'h1_0000_0000;
                    if (target % 4 != 0) m_phase = PH_DEAD;
                    else begin
                        m_pc    = target[31:0];
                        m_phase = PH_ISSUE;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_req_valid", 32'(imem_req_valid), 32'(rst_n && m_phase == PH_ISSUE));
            if (rst_n && m_phase == PH_ISSUE) chk("m_imem_addr", imem_addr, m_pc);
            chk("m_instr_valid", 32'(instr_valid), 32'(m_phase == PH_HELD));
            chk("m_fault", 32'(fetch_fault), 32'(m_phase == PH_DEAD));
            chk("m_pc", pc, m_pc);
            chk("m_instr", instr, m_instr);
            chk("m_opcode", 32'(opcode), 32'(m_instr & 32'h7F));
            chk("m_funct3", 32'(funct3), 32'((m_instr >> 12) & 32'h7));
            chk("m_funct7", 32'(funct7), 32'(m_instr >> 25));
        end
    end

    // Returns just after a falling edge; inputs are driven from here.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_err = 0;
        instr_ready = 0; branch_taken = 0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Complete a fetch from S_REQ: accept, then respond one cycle later.
    task automatic fetch(input logic [31:0] data);
        imem_req_ready = 1; tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = data; tick();
        imem_rsp_valid = 0;
    endtask

    task automatic retire(input logic bt, input logic [31:0] tgt);
        instr_ready = 1; branch_taken = bt; branch_target = tgt; tick();
        instr_ready = 0; branch_taken = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick(); tick();
        cmp_en = 1'b1;
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_instr_nop", instr, NOP);
        chk("rst_fault", 32'(fetch_fault), 0);
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_pc", pc, RST_PC);

        rst_n = 1'b1; tick();
        chk("first_req_valid", 32'(imem_req_valid), 1);
        chk("first_addr", imem_addr, 32'h0);
        fetch(32'h0050_0093);
        chk("f1_valid", 32'(instr_valid), 1);
        chk("f1_opcode", 32'(opcode), 32'h13);
        chk("f1_funct3", 32'(funct3), 0);
        chk("f1_pc", pc, 0);
        chk("f1_instr", instr, 32'h0050_0093);

        retire(1'b0, 32'h0);
        chk("seq_req_valid", 32'(imem_req_valid), 1);
        chk("seq_addr", imem_addr, 32'h4);
        chk("seq_instr_valid", 32'(instr_valid), 0);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req_valid", 32'(imem_req_valid), 1);
            chk("stall_addr", imem_addr, 32'h4);
            chk("stall_instr_valid", 32'(instr_valid), 0);
        end

        imem_req_ready = 1; tick();
        imem_req_ready = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("slow_wait_valid", 32'(instr_valid), 0);
            chk("slow_wait_req", 32'(imem_req_valid), 0);
        end
        imem_rsp_valid = 1; imem_rsp_data = 32'h0020_8133; tick();
        imem_rsp_valid = 0;
        chk("slow_valid", 32'(instr_valid), 1);
        chk("slow_funct7", 32'(funct7), 0);
        chk("slow_opcode", 32'(opcode), 32'h33);
        chk("slow_pc", pc, 32'h4);

        retire(1'b1, 32'h40);
        chk("br_addr", imem_addr, 32'h40);
        fetch(32'h4000_0033);
        chk("br_pc", pc, 32'h40);
        chk("br_funct7", 32'(funct7), 32'h20);

        retire(1'b1, 32'hFFFF_FFFC);
        chk("wrap_hi_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        retire(1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        fetch(32'h0000_0013);

        retire(1'b1, 32'h42);
        chk("mis_fault", 32'(fetch_fault), 1);
        chk("mis_instr_valid", 32'(instr_valid), 0);
        chk("mis_pc", pc, 32'h0);
        imem_req_ready = 1; imem_rsp_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mis_no_req", 32'(imem_req_valid), 0);
            chk("mis_sticky", 32'(fetch_fault), 1);
        end

        do_reset(); tick();
        imem_req_ready = 1; tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_err = 1; tick();
        imem_rsp_valid = 0; imem_rsp_err = 0;
        chk("err_fault", 32'(fetch_fault), 1);
        chk("err_instr_valid", 32'(instr_valid), 0);

        do_reset(); tick();
        imem_req_ready = 1; tick();
        imem_req_ready = 0; rst_n = 0; tick();
        rst_n = 1; imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; tick();
        imem_rsp_valid = 0;
        chk("late_instr_valid", 32'(instr_valid), 0);
        chk("late_req_valid", 32'(imem_req_valid), 1);
        chk("late_addr", imem_addr, RST_PC);
        chk("late_instr", instr, NOP);

        for (int i = 0; i < 4000; i++) begin
            rst_n          = ($urandom_range(0, 99) >= 2);
            imem_req_ready = $urandom_range(0, 2) != 0;
            imem_rsp_valid = $urandom_range(0, 2) != 0;
            imem_rsp_err   = $urandom_range(0, 49) == 0;
            imem_rsp_data  = $urandom;
            instr_ready    = $urandom_range(0, 1) != 0;
            branch_taken   = $urandom_range(0, 3) == 0;
            case ($urandom_range(0, 19))
                0:       branch_target = $urandom;
                1:       branch_target = 32'hFFFF_FFFC;
                default: branch_target = {$urandom_range(0, 32'h3FFF), 2'b00};
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Sits directly upstream of the decoder/control unit.
- Owns the program counter and issues word requests to instruction memory over a valid/ready request channel with a variable-latency response.
- Holds the fetched instruction stable for decode and splits out opcode, funct3 and funct7.
- Advances the PC to PC+4 or to the resolved branch target when the core retires the held instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, addresses and instruction word.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  XLEN  returned instruction word.
- imem_rsp_err  in  1  bus error qualifying the response.
- instr_valid  out  1  instr/pc hold a valid instruction.
- instr_ready  in  1  core retires the held instruction this cycle.
- instr  out  XLEN  held instruction.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- pc  out  XLEN  address of held instruction.
- branch_taken  in  1  held instruction redirects; sampled only on retire.
- branch_target  in  XLEN  redirect address; sampled only on retire.
- fetch_fault  out  1  sticky fault: misaligned target or bus error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low: sampled only at the rising edge of clk.
- Reset values:
  - pc=RESET_PC; state=S_REQ.
  - instr_valid=0, instr=32'h0000_0013 (NOP, so decode sees addi x0,x0,0).
  - fetch_fault=0, imem_req_valid=0 during reset.
  - Internal PC register = RESET_PC.
- States S_REQ, S_WAIT, S_HOLD, S_FAULT. Registered FSM. Outputs are registered or decoded from state only: no combinational path from imem_* inputs to outputs.
- S_REQ:
  - imem_req_valid=1, imem_addr=PC.
  - Valid and address stay stable until imem_req_ready=1, then go to S_WAIT.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid & !imem_rsp_err: latch instr=imem_rsp_data, set instr_valid=1, go to S_HOLD.
  - On imem_rsp_valid & imem_rsp_err: go to S_FAULT.
  - Responses are only accepted in S_WAIT; any response in another state is ignored.
- S_HOLD:
  - instr, pc and decoded fields stable while instr_valid=1.
  - On instr_ready:
    - nxt = branch_taken ? branch_target : PC+4, with modulo-2^XLEN wrap (32'hFFFF_FFFC+4 = 0).
    - If nxt[1:0]!=0: go to S_FAULT.
    - Otherwise PC<=nxt, instr_valid<=0, go to S_REQ.
- S_FAULT:
  - fetch_fault=1, instr_valid=0, imem_req_valid=0.
  - Terminal until reset; pc holds the last retired instruction's address.
- Latency:
  - Request accepted at edge N. Response earliest in cycle N+1, latched at edge N+1.
  - instr_valid=1 from edge N+1 onward.
  - Retire at edge M puts the next request on the bus in cycle M+1.
- Throughput: one instruction at most every 3 cycles; matches single-cycle core pacing.
- Simultaneous events:
  - imem_req_ready asserted in the same cycle rst_n is low: reset wins, no transaction is recorded.
  - Reset mid-S_WAIT: a late response arriving after reset lands in S_REQ and is dropped.
  - instr_ready while instr_valid=0: ignored.
- pc output equals the PC register at all times; decoded fields are pure slices of instr.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants: OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011;
  - NOP_INSTR=32'h0000_0013;
  - XLEN default;
  - the fetch_state_t enum.
- No sub-module: next-PC logic is a single adder/mux kept inline.

Test Plan:
- Reset, then imem_req_ready=1, response 32'h00500093 one cycle later:
  - imem_addr=0 in the first cycle after reset;
  - instr_valid=1, opcode=7'b0010011, funct3=0, pc=0 two cycles after acceptance.
- Retire with branch_taken=0: next imem_addr=4. Retire with branch_taken=1, branch_target=32'h40: next imem_addr=32'h40, pc=32'h40 after the fetch completes.
- Hold imem_req_ready=0 for 5 cycles: imem_req_valid=1 and imem_addr unchanged every cycle; no instr_valid.
- Respond 3 cycles after acceptance: instr_valid stays 0 during the wait; instr_valid=1 one edge after rsp_valid.
- branch_target=32'h42 on retire -> fetch_fault=1 next cycle, no further imem_req_valid until reset. Separately, imem_rsp_err=1 -> fetch_fault=1, instr_valid=0.
- rst_n low for 1 cycle while in S_WAIT, response arrives the cycle after release:
  - response ignored;
  - imem_req_valid=1 with addr=RESET_PC;
  - instr=NOP.
